// File: rtl/td4_prog_mem_pkg.sv
// ============================================================================
//  Module      : td4_pkg
//  Description : Shared types and default widths for the TD4 program memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package td4_pkg;

  // Default geometry: 16 words of 4-bit opcode + 4-bit immediate
  localparam int TD4_ADDR_W = 4;
  localparam int TD4_OP_W   = 4;
  localparam int TD4_IMM_W  = 4;

  // Controller states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } td4_state_e;

endpackage : td4_pkg

`default_nettype wire

// File: rtl/td4_prog_mem_if.sv
// ============================================================================
//  Module      : td4_prog_mem_if
//  Description : Load-stream and fetch bus for the TD4 program memory.
//                The parity_err signal exists only when
//                TD4_PROG_MEM_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface td4_prog_mem_if
  import td4_pkg::*;
#(
  parameter int ADDR_W = TD4_ADDR_W,
  parameter int OP_W   = TD4_OP_W,
  parameter int IMM_W  = TD4_IMM_W
) ();

  // Load stream
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_len;
  logic              load_valid;
  logic              load_ready;
  logic [OP_W-1:0]   load_op;
  logic [IMM_W-1:0]  load_imm;
  logic              load_done;
  logic              busy;

  // Fetch port
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [OP_W-1:0]   fetch_op;
  logic [IMM_W-1:0]  fetch_imm;
  logic              fetch_valid;

`ifdef TD4_PROG_MEM_PARITY_EN
  logic              parity_err;

  modport master (
    output load_start, load_base, load_len, load_valid, load_op, load_imm,
    output fetch_en, fetch_addr,
    input  load_ready, load_done, busy,
    input  fetch_op, fetch_imm, fetch_valid, parity_err
  );

  modport slave (
    input  load_start, load_base, load_len, load_valid, load_op, load_imm,
    input  fetch_en, fetch_addr,
    output load_ready, load_done, busy,
    output fetch_op, fetch_imm, fetch_valid, parity_err
  );
`else
  modport master (
    output load_start, load_base, load_len, load_valid, load_op, load_imm,
    output fetch_en, fetch_addr,
    input  load_ready, load_done, busy,
    input  fetch_op, fetch_imm, fetch_valid
  );

  modport slave (
    input  load_start, load_base, load_len, load_valid, load_op, load_imm,
    input  fetch_en, fetch_addr,
    output load_ready, load_done, busy,
    output fetch_op, fetch_imm, fetch_valid
  );
`endif

endinterface : td4_prog_mem_if

`default_nettype wire

// File: rtl/td4_mem_array.sv
// ============================================================================
//  Module      : td4_mem_array
//  Description : DEPTH x DATA_W storage with synchronous write and a
//                synchronous, enable-gated read register. No reset: the
//                contents and the read register survive a system reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module td4_mem_array #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and read register; the read register holds while re is low
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : td4_mem_array

`default_nettype wire

// File: rtl/td4_prog_mem.sv
// ============================================================================
//  Module      : td4_prog_mem
//  Description : TD4 program memory. Streams a program in through a
//                handshaked load port (auto-incrementing, wrapping write
//                pointer) and serves the CPU fetch port with one-cycle
//                latency. Optional even-parity protection of each word is
//                enabled by defining TD4_PROG_MEM_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module td4_prog_mem
  import td4_pkg::*;
#(
  parameter int ADDR_W = TD4_ADDR_W,
  parameter int OP_W   = TD4_OP_W,
  parameter int IMM_W  = TD4_IMM_W
) (
  input logic          clk,
  input logic          rst,
  td4_prog_mem_if.slave bus
);

  localparam int WORD_W = OP_W + IMM_W;
`ifdef TD4_PROG_MEM_PARITY_EN
  localparam int STORE_W = WORD_W + 1;
`else
  localparam int STORE_W = WORD_W;
`endif

  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_LOAD = 1'(LOAD);

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic              load_done_q;
  logic              fetch_valid_q;
  // Set by the first fetch after reset; until then the fetch outputs read
  // as zero because the unreset read register may hold stale data.
  logic              have_data;

  logic              in_idle;
  logic              in_load;
  logic              accept;
  logic              fetch_go;
  logic              len_zero;
  logic [WORD_W-1:0] wr_word;
  logic [STORE_W-1:0] wr_data;
  logic [STORE_W-1:0] rd_data;

  assign in_idle  = (state == ST_IDLE);
  assign in_load  = (state == ST_LOAD);
  assign accept   = in_load && bus.load_valid;
  assign fetch_go = in_idle && bus.fetch_en;
  assign len_zero = (bus.load_len == '0);
  assign wr_word  = {bus.load_op, bus.load_imm};

`ifdef TD4_PROG_MEM_PARITY_EN
  // Stored parity bit makes the XOR over the whole stored word zero
  assign wr_data  = {^wr_word, wr_word};
`else
  assign wr_data  = wr_word;
`endif

  // Load controller: burst start, pointer/counter update, done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      remaining   <= '0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.load_start) begin
            if (len_zero) begin
              load_done_q <= 1'b1;
            end else begin
              state     <= ST_LOAD;
              ptr       <= bus.load_base;
              remaining <= bus.load_len;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            // ADDR_W-bit add wraps DEPTH-1 -> 0 on its own
            ptr       <= ptr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W + 1)'(1);
            if (remaining == (ADDR_W + 1)'(1)) begin
              state       <= ST_IDLE;
              load_done_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Fetch status: valid follows a serviced request by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid_q <= 1'b0;
      have_data     <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_go;
      if (fetch_go) begin
        have_data <= 1'b1;
      end
    end
  end

  td4_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (STORE_W)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (ptr),
    .wdata (wr_data),
    .re    (fetch_go),
    .raddr (bus.fetch_addr),
    .rdata (rd_data)
  );

  assign bus.load_ready  = in_load;
  assign bus.busy        = in_load;
  assign bus.load_done   = load_done_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_op    = have_data ? rd_data[WORD_W-1:IMM_W] : '0;
  assign bus.fetch_imm   = have_data ? rd_data[IMM_W-1:0]      : '0;

`ifdef TD4_PROG_MEM_PARITY_EN
  // Any odd XOR over the stored word means a flipped bit
  assign bus.parity_err  = have_data && (^rd_data);
`endif

endmodule : td4_prog_mem

`default_nettype wire

// File: doc/td4_prog_mem.md
# td4_prog_mem

Parametrised program memory for the TD4 core: stores instruction words split into opcode and immediate fields, with a handshaked streaming load port and a registered fetch port. The load port auto-increments a write pointer from a base address over a programmable word count, so a program can be streamed in from the pins. The fetch port serves the CPU's program counter with one-cycle latency. It replaces the fixed 16 x 8 memory with depth and field widths set by parameters.

## Interface
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- OP_W, 4, opcode field width
- IMM_W, 4, immediate field width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- load_start  in  1  pulse; begins a load burst (honoured in IDLE only)
- load_base  in  ADDR_W  first write address, sampled with load_start
- load_len  in  ADDR_W+1  word count 0..DEPTH, sampled with load_start
- load_valid  in  1  load word present
- load_ready  out  1  block accepts a load word
- load_op  in  OP_W  opcode of load word
- load_imm  in  IMM_W  immediate of load word
- load_done  out  1  one-cycle pulse, burst finished
- busy  out  1  high while in LOAD
- fetch_en  in  1  fetch request
- fetch_addr  in  ADDR_W  fetch address
- fetch_op  out  OP_W  fetched opcode
- fetch_imm  out  IMM_W  fetched immediate
- fetch_valid  out  1  fetch_op/fetch_imm hold a fresh fetch result
- parity_err  out  1  present only with TD4_PROG_MEM_PARITY_EN

## Operation
- States: IDLE, LOAD.
- IDLE -> LOAD on load_start with load_len != 0: ptr <= load_base, remaining <= load_len.
- load_start with load_len == 0: no writes; load_done pulses next cycle; stays IDLE.
- load_start in LOAD: ignored.
- LOAD: load_ready = 1. A word is accepted when load_valid && load_ready: mem[ptr] <= {load_op, load_imm}, ptr <= ptr + 1 mod DEPTH (wraps DEPTH-1 -> 0), remaining decrements.
- Acceptance of the final word (remaining == 1) -> IDLE next cycle, load_done pulses that same cycle.
- load_len == DEPTH with any base: every word written exactly once, pointer wraps.
- Fetch serviced only in IDLE. fetch_en in LOAD is ignored: fetch_valid drops to 0, fetch_op/fetch_imm hold their previous values.
- fetch_en and load_start in the same IDLE cycle: fetch returns pre-load contents; LOAD begins.
- The memory array is not reset; its contents survive rst. Unwritten words read as unknown.

## Timing
- Reset values: load_ready 0, load_done 0, busy 0, fetch_op 0, fetch_imm 0, fetch_valid 0, parity_err 0, state IDLE, ptr 0, remaining 0.
- rst mid-burst: immediate abort to IDLE. Words already accepted stay written; no load_done pulse.
- Fetch latency: fetch_en at edge N -> data and fetch_valid = 1 after edge N+1.
- fetch_valid stays 1 while fetch_en is held. It falls to 0 one cycle after fetch_en deasserts; data holds.
- busy = (state == LOAD). load_ready is combinational from state.
- Load throughput: one word per cycle.

## Configuration
- TD4_PROG_MEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit over {op, imm}, computed on write.
  - On fetch, parity_err is registered alongside data: it is 1 when the stored parity mismatches and 0 on a clean fetch.
- Undefined: no parity storage, and the parity_err port is absent.

## Structure
- Package td4_pkg: state enum (IDLE, LOAD) and default width constants (TD4_ADDR_W=4, TD4_OP_W=4, TD4_IMM_W=4).
- Sub-module td4_mem_array:
  - DEPTH x (OP_W+IMM_W[+1]) storage.
  - Synchronous write, synchronous read, no reset.
- Top holds the FSM, pointer, counter and output registers.

## Test plan
- Reset asserted mid-cycle -> all outputs go to reset values immediately (asynchronous), state IDLE.
- load_base=0, load_len=16, stream words i -> {op=i, imm=15-i} with load_valid always 1:
  - exactly 16 accepts, load_done one cycle after the 16th;
  - fetch addr 5 -> op=5, imm=10 one cycle later.
- load_base=14, load_len=4 with a load_valid gap of 3 cycles after the 2nd word -> writes at 14, 15, 0, 1. load_ready stays 1 through the gap; busy stays high until done.
- fetch_en=1 during LOAD -> fetch_valid=0 and outputs unchanged. load_len=0 -> load_done pulse, no busy, memory unchanged.
- rst after 2 of 8 words -> IDLE, no load_done. The 2 words read back; the 3rd address keeps its old value.
- With TD4_PROG_MEM_PARITY_EN: force a stored parity bit flip at addr 3 -> fetch addr 3 gives parity_err=1; fetch addr 4 gives parity_err=0.
